fetch_stage: RTL

- Instruction-fetch stage directly upstream of instruction_memory.
- Owns the program counter and drives it to the memory's `pc` input.
- Captures the combinational instruction returned by the memory into a registered IF/ID slot, using a valid/ready handshake toward decode.
- Handles branch/jump redirects from EX, stalls from ID, and halts on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage that owns the PC and fills a registered IF/ID slot.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr           fetch address to instruction memory (copy of pc_q)
//   imem_rdata          combinational instruction from instruction memory
//   redirect_valid      EX redirect request (taken branch/jump)
//   redirect_target     redirect byte address
//   id_ready            decode accepts the IF/ID slot this cycle
//   id_valid/id_instr/id_pc/id_pc_plus4   registered IF/ID slot
//   fetch_fault         sticky fault: misaligned redirect or out-of-range PC
//   halted              stage is in HALT
//   perf_fetched/perf_stalls   only when FETCH_PERF_EN is defined
//
// Optional feature macro: FETCH_PERF_EN (fetch and stall counters).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
`endif
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        fault_q, fault_d;
    logic        take, capture, tgt_bad, pc_oor;

    assign take    = !valid_q || id_ready;
    assign tgt_bad = (redirect_target[1:0] != 2'b00) || ({2'b00, redirect_target[31:2]} >= WORDS);
    assign pc_oor  = {2'b00, pc_q[31:2]} >= WORDS;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        fault_d = fault_q;
        capture = 1'b0;
        if (redirect_valid) begin
            // The slot is wrong-path; a concurrent handshake still counts as delivered.
            valid_d = 1'b0;
            if (tgt_bad) begin
                fault_d = 1'b1;
                state_d = HALT;
            end else begin
                pc_d    = redirect_target;
                state_d = RUN;
            end
        end else if (take) begin
            if (state_q == HALT) begin
                valid_d = 1'b0;
            end else if (pc_oor) begin
                fault_d = 1'b1;
                state_d = HALT;
                valid_d = 1'b0;
            end else begin
                capture = 1'b1;
                instr_d = imem_rdata;
                ipc_d   = pc_q;
                ipc4_d  = pc_q + 32'd4;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_q + {31'd0, capture};
            stalls_q  <= stalls_q + {31'd0, (state_q == RUN) && valid_q && !id_ready};
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    // Counters are not built; capture only steers the slot.
`endif

    assign imem_addr   = pc_q;
    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc       = ipc_q;
    assign id_pc_plus4 = ipc4_q;
    assign fetch_fault = fault_q;
    assign halted      = (state_q == HALT);
endmodule
